// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a multiplexed 4-digit 7-segment drive and assembles
// them into 16-bit frames with per-digit illegal-pattern flags and a ready/valid output.
module seg7_scan_decoder #(
  parameter int STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_sel,
  input  logic        frame_ready,
  output logic [15:0] bcd_out,
  output logic        frame_valid,
  output logic [3:0]  dig_err,
  output logic        overrun
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYC);
  // The first new sample leaves the counter at 0, so the STABLE_CYC-th one is seen at STABLE_CYC-2.
  localparam logic [3:0] CAP_AT  = 4'(STABLE_CYC - 2);

  logic [10:0] samp_reg;
  logic [10:0] prev_reg;
  logic [3:0]  cnt_reg;
  logic [3:0]  mask_reg;
  logic [3:0]  val_reg [4];
  logic        err_reg [4];

  logic [3:0]  sel;
  logic [6:0]  seg;
  logic        same;
  logic        one_hot;
  logic        capture;
  logic [4:0]  dec;
  logic [3:0]  mask_next;
  logic        complete;
  logic [3:0]  slot_val [4];
  logic [3:0]  slot_err;
  logic [15:0] frame_bcd;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: decode = 5'h00;
      7'b0110000: decode = 5'h01;
      7'b1101101: decode = 5'h02;
      7'b1111001: decode = 5'h03;
      7'b0110011: decode = 5'h04;
      7'b1011011: decode = 5'h05;
      7'b1011111: decode = 5'h06;
      7'b1110000: decode = 5'h07;
      7'b1111111: decode = 5'h08;
      7'b1111011: decode = 5'h09;
      7'b0000000: decode = 5'h0F;
      default:    decode = 5'h1E;
    endcase
  endfunction

  assign sel       = samp_reg[10:7];
  assign seg       = samp_reg[6:0];
  assign same      = (samp_reg == prev_reg);
  assign one_hot   = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  assign capture   = same && one_hot && (cnt_reg == CAP_AT);
  assign dec       = decode(seg);
  assign mask_next = mask_reg | (capture ? sel : 4'd0);
  assign complete  = capture && (mask_next == 4'hF);

  // Slot contents as they will be after this edge, so a completing frame includes its last digit.
  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    assign slot_val[gi] = (capture && sel[gi]) ? dec[3:0] : val_reg[gi];
    assign slot_err[gi] = (capture && sel[gi]) ? dec[4]   : err_reg[gi];
    assign frame_bcd[gi*4 +: 4] = slot_val[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        val_reg[gi] <= 4'd0;
        err_reg[gi] <= 1'b0;
      end else begin
        val_reg[gi] <= slot_val[gi];
        err_reg[gi] <= slot_err[gi];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_reg    <= '0;
      prev_reg    <= '0;
      cnt_reg     <= '0;
      mask_reg    <= '0;
      bcd_out     <= '0;
      dig_err     <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      samp_reg <= {dig_sel, seg_in};
      prev_reg <= samp_reg;

      if (!(same && one_hot))
        cnt_reg <= '0;
      else if (cnt_reg < CNT_MAX)
        cnt_reg <= cnt_reg + 4'd1;

      mask_reg <= complete ? 4'd0 : mask_next;

      if (complete && (!frame_valid || frame_ready)) begin
        bcd_out     <= frame_bcd;
        dig_err     <= slot_err;
        frame_valid <= 1'b1;
      end else begin
        if (complete)
          overrun <= 1'b1;
        if (frame_valid && frame_ready)
          frame_valid <= 1'b0;
      end
    end
  end

endmodule
